// File: rtl/packed_macc_pe_if.sv
// Systolic PE bus: activation/weight streams, framing, psum chain and status.
// The slave side is the PE; the master side is whatever feeds and observes it.
interface packed_macc_pe_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 2,
  parameter int ACC_W  = 24
) ();
  logic [DATA_W-1:0]       left_in;
  logic                    left_vld;
  logic                    acc_first;
  logic                    acc_last;
  logic [LANES*DATA_W-1:0] top_in;
  logic [DATA_W-1:0]       right_out;
  logic                    right_vld;
  logic                    right_first;
  logic                    right_last;
  logic [LANES*DATA_W-1:0] bottom_out;
  logic                    psum_sel;
  logic [LANES*ACC_W-1:0]  psum_in;
  logic                    psum_in_vld;
  logic [LANES*ACC_W-1:0]  psum_out;
  logic                    psum_out_vld;
  logic                    clr_status;
  logic                    sat_flag;
  logic                    ovr_flag;

  modport slave (
    input  left_in, left_vld, acc_first, acc_last, top_in,
    input  psum_sel, psum_in, psum_in_vld, clr_status,
    output right_out, right_vld, right_first, right_last, bottom_out,
    output psum_out, psum_out_vld, sat_flag, ovr_flag
  );

  modport master (
    output left_in, left_vld, acc_first, acc_last, top_in,
    output psum_sel, psum_in, psum_in_vld, clr_status,
    input  right_out, right_vld, right_first, right_last, bottom_out,
    input  psum_out, psum_out_vld, sat_flag, ovr_flag
  );
endinterface

// File: rtl/packed_macc_pe.sv
// Output-stationary systolic PE with LANES packed weight lanes sharing one
// activation. Three-stage MAC (operand reg, product reg, saturating
// accumulate), one-entry result buffer, and a registered vertical psum chain.
//
// Result buffer FSM:
//   state     | meaning
//   BUF_EMPTY | no undrained result held
//   BUF_FULL  | result_buf holds a result not yet emitted on psum_out
module packed_macc_pe #(
  parameter int DATA_W = 8,
  parameter int LANES  = 2,
  parameter int ACC_W  = 24
) (
  input logic             clk,
  input logic             rst_n,
  packed_macc_pe_if.slave bus
);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  buf_state_t state, state_nxt;

  logic [DATA_W-1:0]            s1_a;
  logic [LANES*DATA_W-1:0]      s1_w;
  logic                         s1_vld, s1_first, s1_last;
  logic [LANES-1:0][PROD_W-1:0] s2_p;
  logic                         s2_vld, s2_first, s2_last;
  logic [LANES-1:0][ACC_W-1:0]  acc, acc_nxt, result_buf;
  logic [LANES-1:0][ACC_W:0]    sum_ext;
  logic [LANES-1:0]             lane_sat;
  logic                         last_evt, sat_set, ovr_set;

  // Neighbour forwarding: fixed 1-cycle hop, regardless of valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.right_out   <= '0;
      bus.right_vld   <= 1'b0;
      bus.right_first <= 1'b0;
      bus.right_last  <= 1'b0;
      bus.bottom_out  <= '0;
    end else begin
      bus.right_out   <= bus.left_in;
      bus.right_vld   <= bus.left_vld;
      bus.right_first <= bus.acc_first;
      bus.right_last  <= bus.acc_last;
      bus.bottom_out  <= bus.top_in;
    end
  end

  // S1 operand capture and S2 per-lane product; only the valid bit gates work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_a     <= '0;
      s1_w     <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s2_p     <= '0;
      s2_vld   <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s1_a     <= bus.left_in;
      s1_w     <= bus.top_in;
      s1_vld   <= bus.left_vld;
      s1_first <= bus.acc_first;
      s1_last  <= bus.acc_last;
      for (int l = 0; l < LANES; l++) begin
        s2_p[l] <= PROD_W'(s1_a) * PROD_W'(s1_w[l*DATA_W +: DATA_W]);
      end
      s2_vld   <= s1_vld;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
  end

  // S3 next accumulator: one extra bit catches overflow, then clamp to max.
  always_comb begin
    sum_ext  = '0;
    acc_nxt  = acc;
    lane_sat = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_ext[l]  = (s2_first ? {(ACC_W+1){1'b0}} : {1'b0, acc[l]})
                    + (ACC_W+1)'(s2_p[l]);
      lane_sat[l] = sum_ext[l][ACC_W];
      acc_nxt[l]  = lane_sat[l] ? ACC_MAX : sum_ext[l][ACC_W-1:0];
    end
    sat_set  = s2_vld & (|lane_sat);
    last_evt = s2_vld & s2_last;
  end

  // S3 accumulator register and result buffer load on a last beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      result_buf <= '0;
    end else begin
      if (s2_vld) acc <= acc_nxt;
      if (last_evt) result_buf <= acc_nxt;
    end
  end

  // Buffer FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= BUF_EMPTY;
    else        state <= state_nxt;
  end

  // Buffer FSM next state; a drain coinciding with a new result keeps FULL.
  always_comb begin
    state_nxt = state;
    ovr_set   = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (last_evt) state_nxt = BUF_FULL;
      end
      BUF_FULL: begin
        if (last_evt && !bus.psum_sel)      ovr_set   = 1'b1;
        else if (!last_evt && bus.psum_sel) state_nxt = BUF_EMPTY;
      end
      default: state_nxt = BUF_EMPTY;
    endcase
  end

  // Psum chain: emit own buffer or pass the PE above through; data holds when invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.psum_out     <= '0;
      bus.psum_out_vld <= 1'b0;
    end else if (bus.psum_sel) begin
      bus.psum_out_vld <= (state == BUF_FULL);
      if (state == BUF_FULL) bus.psum_out <= result_buf;
    end else begin
      bus.psum_out_vld <= bus.psum_in_vld;
      if (bus.psum_in_vld) bus.psum_out <= bus.psum_in;
    end
  end

  // Sticky status; a set in the same cycle as clr_status wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.sat_flag <= 1'b0;
      bus.ovr_flag <= 1'b0;
    end else begin
      bus.sat_flag <= sat_set | (bus.sat_flag & ~bus.clr_status);
      bus.ovr_flag <= ovr_set | (bus.ovr_flag & ~bus.clr_status);
    end
  end
endmodule

// File: tb/tb_packed_macc_pe.sv
// Directed bench for packed_macc_pe: a 24-bit and a 17-bit accumulator
// instance share the same stimulus; the 17-bit one exposes saturation.
module tb_packed_macc_pe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  left_in = '0;
  logic        left_vld = 1'b0, acc_first = 1'b0, acc_last = 1'b0;
  logic [15:0] top_in = '0;
  logic        psum_sel = 1'b0, psum_in_vld = 1'b0, clr_status = 1'b0;
  logic [23:0] pin1 = '0, pin0 = '0;

  packed_macc_pe_if #(.DATA_W(8), .LANES(2), .ACC_W(24)) bus24 ();
  packed_macc_pe_if #(.DATA_W(8), .LANES(2), .ACC_W(17)) bus17 ();

  assign bus24.left_in     = left_in;
  assign bus24.left_vld    = left_vld;
  assign bus24.acc_first   = acc_first;
  assign bus24.acc_last    = acc_last;
  assign bus24.top_in      = top_in;
  assign bus24.psum_sel    = psum_sel;
  assign bus24.psum_in     = {pin1, pin0};
  assign bus24.psum_in_vld = psum_in_vld;
  assign bus24.clr_status  = clr_status;
  assign bus17.left_in     = left_in;
  assign bus17.left_vld    = left_vld;
  assign bus17.acc_first   = acc_first;
  assign bus17.acc_last    = acc_last;
  assign bus17.top_in      = top_in;
  assign bus17.psum_sel    = psum_sel;
  assign bus17.psum_in     = {pin1[16:0], pin0[16:0]};
  assign bus17.psum_in_vld = psum_in_vld;
  assign bus17.clr_status  = clr_status;

  packed_macc_pe #(.DATA_W(8), .LANES(2), .ACC_W(24)) dut24 (
    .clk(clk), .rst_n(rst_n), .bus(bus24));
  packed_macc_pe #(.DATA_W(8), .LANES(2), .ACC_W(17)) dut17 (
    .clk(clk), .rst_n(rst_n), .bus(bus17));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] w1, input logic [7:0] w0,
                      input logic f, input logic l);
    left_in = a; top_in = {w1, w0}; left_vld = 1'b1; acc_first = f; acc_last = l;
    tick();
    left_vld = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; psum_sel = 1'b0; psum_in_vld = 1'b0; clr_status = 1'b0;
    left_vld = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic expect_drain(input string name, input logic [23:0] e1, input logic [23:0] e0);
    psum_sel = 1'b1;
    tick();
    chk({name, "_vld"}, bus24.psum_out_vld, 1'b1);
    chk({name, "_psum"}, bus24.psum_out, {e1, e0});
    psum_sel = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic        v, f, l;
    logic [15:0] w;
    logic [23:0] p1, p0;
    logic        pv;
    logic [23:0] e1, e0;
    logic        ev;
  } fwd_vec_t;

  typedef struct {
    logic [7:0]  a, w1, w0;
    logic [23:0] e1, e0;
  } frame_vec_t;

  fwd_vec_t   fwd_tab[5];
  frame_vec_t frm_tab[4];

  initial begin
    fwd_tab[0] = '{8'h11, 1'b1, 1'b1, 1'b0, 16'hA55A, 24'd1, 24'd2, 1'b1, 24'd1, 24'd2, 1'b1};
    fwd_tab[1] = '{8'hFF, 1'b0, 1'b0, 1'b1, 16'h0000, 24'd7, 24'd9, 1'b0, 24'd1, 24'd2, 1'b0};
    fwd_tab[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 16'hFFFF, 24'hFFFFFF, 24'd0, 1'b1, 24'hFFFFFF, 24'd0, 1'b1};
    fwd_tab[3] = '{8'h80, 1'b0, 1'b1, 1'b0, 16'h1234, 24'd3, 24'd4, 1'b1, 24'd3, 24'd4, 1'b1};
    fwd_tab[4] = '{8'h7E, 1'b1, 1'b0, 1'b0, 16'h00FF, 24'd5, 24'd6, 1'b0, 24'd3, 24'd4, 1'b0};
    frm_tab[0] = '{8'd255, 8'd255, 8'd255, 24'd65025, 24'd65025};
    frm_tab[1] = '{8'd1,   8'd0,   8'd200, 24'd0,     24'd200};
    frm_tab[2] = '{8'd16,  8'd3,   8'd17,  24'd48,    24'd272};
    frm_tab[3] = '{8'd0,   8'd9,   8'd9,   24'd0,     24'd0};

    // Reset with random inputs: every output stays 0, no emission with psum_sel=1.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      left_in = 8'($urandom); top_in = 16'($urandom); left_vld = 1'($urandom);
      acc_first = 1'($urandom); acc_last = 1'($urandom); psum_sel = 1'b1;
      pin1 = 24'($urandom); pin0 = 24'($urandom); psum_in_vld = 1'($urandom);
      clr_status = 1'($urandom);
      tick();
      chk("rst_right_out", bus24.right_out, '0);
      chk("rst_right_ctl", {bus24.right_vld, bus24.right_first, bus24.right_last}, '0);
      chk("rst_bottom_out", bus24.bottom_out, '0);
      chk("rst_psum_out", bus24.psum_out, '0);
      chk("rst_psum_vld", bus24.psum_out_vld, '0);
      chk("rst_flags", {bus24.sat_flag, bus24.ovr_flag}, '0);
      chk("rst_all17", {bus17.right_out, bus17.right_vld, bus17.right_first, bus17.right_last,
                        bus17.bottom_out, bus17.psum_out, bus17.psum_out_vld,
                        bus17.sat_flag, bus17.ovr_flag}, '0);
    end
    do_reset();

    // Forwarding and psum pass-through: one-cycle latency, hold when invalid.
    for (int i = 0; i < 5; i++) begin
      left_in = fwd_tab[i].a; left_vld = fwd_tab[i].v; acc_first = fwd_tab[i].f;
      acc_last = fwd_tab[i].l; top_in = fwd_tab[i].w; psum_sel = 1'b0;
      pin1 = fwd_tab[i].p1; pin0 = fwd_tab[i].p0; psum_in_vld = fwd_tab[i].pv;
      tick();
      chk($sformatf("fwd%0d_right_out", i), bus24.right_out, fwd_tab[i].a);
      chk($sformatf("fwd%0d_right_ctl", i), {bus24.right_vld, bus24.right_first, bus24.right_last},
          {fwd_tab[i].v, fwd_tab[i].f, fwd_tab[i].l});
      chk($sformatf("fwd%0d_bottom_out", i), bus24.bottom_out, fwd_tab[i].w);
      chk($sformatf("fwd%0d_psum_out", i), bus24.psum_out, {fwd_tab[i].e1, fwd_tab[i].e0});
      chk($sformatf("fwd%0d_psum_vld", i), bus24.psum_out_vld, fwd_tab[i].ev);
      chk($sformatf("fwd%0d_right17", i), bus17.right_out, fwd_tab[i].a);
    end
    psum_in_vld = 1'b0;
    do_reset();

    // Three-beat frame with drain held on: result leaves exactly one edge after the buffer loads.
    psum_sel = 1'b1;
    beat(8'd3, 8'd2, 8'd4, 1'b1, 1'b0);
    beat(8'd5, 8'd2, 8'd4, 1'b0, 1'b0);
    beat(8'd7, 8'd2, 8'd4, 1'b0, 1'b1);
    chk("frame_fwd_last", {bus24.right_out, bus24.right_last}, {8'd7, 1'b1});
    chk("frame_vld_e1", bus24.psum_out_vld, 1'b0);
    tick();
    chk("frame_vld_e2", bus24.psum_out_vld, 1'b0);
    tick();
    chk("frame_vld_e3", bus24.psum_out_vld, 1'b0);
    tick();
    chk("frame_vld_e4", bus24.psum_out_vld, 1'b1);
    chk("frame_psum", bus24.psum_out, {24'd30, 24'd60});
    tick();
    chk("frame_vld_e5", bus24.psum_out_vld, 1'b0);
    chk("frame_hold", bus24.psum_out, {24'd30, 24'd60});
    psum_sel = 1'b0;

    // Same frame with bubbles; bubbles carry junk data and framing bits.
    beat(8'd3, 8'd2, 8'd4, 1'b1, 1'b0);
    left_in = 8'd99; acc_first = 1'b1; acc_last = 1'b1; tick();
    acc_first = 1'b0; acc_last = 1'b0;
    beat(8'd5, 8'd2, 8'd4, 1'b0, 1'b0);
    left_in = 8'd77; acc_first = 1'b1; tick(); tick();
    acc_first = 1'b0;
    beat(8'd7, 8'd2, 8'd4, 1'b0, 1'b1);
    tick(); tick();
    expect_drain("bubble", 24'd30, 24'd60);
    psum_sel = 1'b1; tick();
    chk("bubble_empty", bus24.psum_out_vld, 1'b0);
    psum_sel = 1'b0;

    // Single-beat frames (first and last together).
    for (int i = 0; i < 4; i++) begin
      beat(frm_tab[i].a, frm_tab[i].w1, frm_tab[i].w0, 1'b1, 1'b1);
      tick(); tick();
      expect_drain($sformatf("single%0d", i), frm_tab[i].e1, frm_tab[i].e0);
    end

    // Saturation: 3 x 255*255 clamps the 17-bit lanes, not the 24-bit ones.
    do_reset();
    beat(8'd255, 8'd255, 8'd255, 1'b1, 1'b0);
    beat(8'd255, 8'd255, 8'd255, 1'b0, 1'b0);
    beat(8'd255, 8'd255, 8'd255, 1'b0, 1'b1);
    tick(); tick();
    chk("sat17_flag", bus17.sat_flag, 1'b1);
    chk("sat24_flag", bus24.sat_flag, 1'b0);
    psum_sel = 1'b1; tick(); psum_sel = 1'b0;
    chk("sat17_psum", bus17.psum_out, {17'd131071, 17'd131071});
    chk("sat24_psum", bus24.psum_out, {24'd195075, 24'd195075});
    tick(); tick();
    chk("sat17_sticky", bus17.sat_flag, 1'b1);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    chk("sat17_clr", bus17.sat_flag, 1'b0);

    // Collision without drain: second result overwrites, ovr_flag set.
    do_reset();
    beat(8'd2, 8'd3, 8'd4, 1'b1, 1'b1);
    beat(8'd5, 8'd1, 8'd1, 1'b1, 1'b1);
    tick(); tick();
    chk("ovr_flag_set", bus24.ovr_flag, 1'b1);
    expect_drain("ovr_new", 24'd5, 24'd5);
    psum_sel = 1'b1; tick(); psum_sel = 1'b0;
    chk("ovr_empty", bus24.psum_out_vld, 1'b0);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    chk("ovr_clr", bus24.ovr_flag, 1'b0);

    // Collision with drain: old value out, new value kept, no overwrite flag.
    do_reset();
    psum_sel = 1'b1;
    beat(8'd2, 8'd3, 8'd4, 1'b1, 1'b1);
    beat(8'd5, 8'd1, 8'd1, 1'b1, 1'b1);
    tick();
    chk("cd_vld_e3", bus24.psum_out_vld, 1'b0);
    tick();
    chk("cd_vld_old", bus24.psum_out_vld, 1'b1);
    chk("cd_psum_old", bus24.psum_out, {24'd6, 24'd8});
    tick();
    chk("cd_vld_new", bus24.psum_out_vld, 1'b1);
    chk("cd_psum_new", bus24.psum_out, {24'd5, 24'd5});
    tick();
    chk("cd_vld_empty", bus24.psum_out_vld, 1'b0);
    chk("cd_ovr", bus24.ovr_flag, 1'b0);
    psum_sel = 1'b0;

    // Reset mid-frame drops the in-flight beat.
    beat(8'd9, 8'd1, 8'd1, 1'b1, 1'b1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    tick(); tick();
    psum_sel = 1'b1; tick(); psum_sel = 1'b0;
    chk("midrst_dropped", bus24.psum_out_vld, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
